// File: rtl/dff_pipe_en.sv
`default_nettype none
// ============================================================================
// Module   : dff_pipe_en
// Purpose  : Elastic pipeline register. Carries a WIDTH-bit word through
//            DEPTH registered stages using a valid/ready handshake. Words
//            move forward into empty stages even while the output is
//            stalled (bubble collapse). The block also has a synchronous
//            flush and a registered occupancy count. With DEPTH = 1 it is
//            a single enable register with a valid bit.
// Ports    : i_clk    - clock, all state changes on the rising edge
//            i_reset  - synchronous active-high reset (takes priority over flush)
//            i_flush  - synchronous flush, clears every valid bit
//            i_valid  - upstream word valid
//            o_ready  - block can accept a word this cycle
//            i_data   - upstream word
//            o_valid  - output word valid (stage DEPTH-1)
//            i_ready  - downstream accepts the output word
//            o_data   - output word (stage DEPTH-1)
//            o_count  - number of valid stages
// Options  : DFF_PIPE_RESET_DATA_EN - when defined, the data registers
//            reset to RESET_VAL. When undefined, only the valid bits are
//            reset, and o_data is unknown until the first load.
// Revision : 1.0 - initial release
// ============================================================================
module dff_pipe_en #(
    parameter int               WIDTH     = 32,
    parameter int               DEPTH     = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic                         i_flush,
    input  logic                         i_valid,
    output logic                         o_ready,
    input  logic [WIDTH-1:0]             i_data,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic [WIDTH-1:0]             o_data,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int                 c_CNT_W   = $clog2(DEPTH + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

    logic [DEPTH-1:0]   r_v;
    logic [WIDTH-1:0]   r_d [DEPTH];
    logic [c_CNT_W-1:0] r_count;

    logic [DEPTH-1:0]   w_adv;
    logic [DEPTH-1:0]   w_vin;
    logic [WIDTH-1:0]   w_din [DEPTH];
    logic               w_tail_full;
    logic               w_in_xfer;
    logic               w_out_xfer;

    // Stage k can advance when some stage at or after k is empty, or when
    // the output is being taken. This is the unrolled form of the chain
    // adv[k] = !v[k] | adv[k+1]. Writing it this way avoids a
    // self-referencing vector in the combinational logic.
    always_comb begin
        w_tail_full = 1'b1;
        w_adv       = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            w_tail_full = w_tail_full & r_v[k];
            w_adv[k]    = !w_tail_full | i_ready;
        end
    end

    assign w_in_xfer  = i_valid & w_adv[0];
    assign w_out_xfer = r_v[DEPTH-1] & i_ready;

    // Connect each stage to the source it loads from.
    assign w_vin[0] = w_in_xfer;
    assign w_din[0] = i_data;

    generate
        for (genvar k = 1; k < DEPTH; k++) begin : g_link
            assign w_vin[k] = r_v[k-1];
            assign w_din[k] = r_d[k-1];
        end
    endgenerate

    // Valid bits. An input accepted in a flush cycle is dropped, because
    // flush clears every stage, stage 0 included.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_flush) begin
            r_v <= '0;
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                if (w_adv[k]) begin
                    r_v[k] <= w_vin[k];
                end
            end
        end
    end

    // Data registers load only when a valid word arrives. Bubbles leave
    // stale data in place, so the registers do not toggle on empty slots.
    always_ff @(posedge i_clk) begin
`ifdef DFF_PIPE_RESET_DATA_EN
        if (i_reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_d[k] <= RESET_VAL;
            end
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                if (w_adv[k] && w_vin[k]) begin
                    r_d[k] <= w_din[k];
                end
            end
        end
`else
        for (int k = 0; k < DEPTH; k++) begin
            if (w_adv[k] && w_vin[k]) begin
                r_d[k] <= w_din[k];
            end
        end
`endif
    end

`ifndef DFF_PIPE_RESET_DATA_EN
    // RESET_VAL has no effect when the data registers have no reset.
    logic w_unused_reset_val;
    assign w_unused_reset_val = ^RESET_VAL;
`endif

    // The occupancy count tracks the popcount of r_v. The saturation guards
    // cannot trigger, because a full pipe accepts only when it also emits.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_flush) begin
            r_count <= '0;
        end else if (w_in_xfer && !w_out_xfer && (r_count != c_CNT_MAX)) begin
            r_count <= r_count + c_CNT_ONE;
        end else if (!w_in_xfer && w_out_xfer && (r_count != '0)) begin
            r_count <= r_count - c_CNT_ONE;
        end
    end

    assign o_ready = w_adv[0];
    assign o_valid = r_v[DEPTH-1];
    assign o_data  = r_d[DEPTH-1];
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_dff_pipe_en.sv
`default_nettype none
// ============================================================================
// Module   : tb_dff_pipe_en
// Purpose  : Directed testbench for dff_pipe_en. It runs a DEPTH=2 instance
//            and a DEPTH=1 instance (both WIDTH=8, RESET_VAL=8'hA5). The
//            expected values are computed by hand.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dff_pipe_en;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DEPTH = 2 instance
    logic       rst2, flush2, valid2, ready2;
    logic [7:0] data2;
    logic       o_ready2, o_valid2;
    logic [7:0] o_data2;
    logic [1:0] o_count2;

    // DEPTH = 1 instance
    logic       rst1, flush1, valid1, ready1;
    logic [7:0] data1;
    logic       o_ready1, o_valid1;
    logic [7:0] o_data1;
    logic [0:0] o_count1;

    int n_pass  = 0;
    int n_total = 0;

    dff_pipe_en #(.WIDTH(8), .DEPTH(2), .RESET_VAL(8'hA5)) u_dut2 (
        .i_clk   (clk),
        .i_reset (rst2),
        .i_flush (flush2),
        .i_valid (valid2),
        .o_ready (o_ready2),
        .i_data  (data2),
        .o_valid (o_valid2),
        .i_ready (ready2),
        .o_data  (o_data2),
        .o_count (o_count2)
    );

    dff_pipe_en #(.WIDTH(8), .DEPTH(1), .RESET_VAL(8'hA5)) u_dut1 (
        .i_clk   (clk),
        .i_reset (rst1),
        .i_flush (flush1),
        .i_valid (valid1),
        .o_ready (o_ready1),
        .i_data  (data1),
        .o_valid (o_valid1),
        .i_ready (ready1),
        .o_data  (o_data1),
        .o_count (o_count1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Inputs are driven and outputs sampled 1 time unit after a rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check valid, count and ready of the DEPTH=2 instance together.
    task automatic chk2(input string tag, input logic v, input logic [1:0] c, input logic r);
        check({tag, ".valid"}, 32'(o_valid2), 32'(v));
        check({tag, ".count"}, 32'(o_count2), 32'(c));
        check({tag, ".ready"}, 32'(o_ready2), 32'(r));
    endtask

    task automatic chk1(input string tag, input logic v, input logic c, input logic r);
        check({tag, ".valid"}, 32'(o_valid1), 32'(v));
        check({tag, ".count"}, 32'(o_count1), 32'(c));
        check({tag, ".ready"}, 32'(o_ready1), 32'(r));
    endtask

    initial begin
        rst2 = 1'b1; flush2 = 1'b0; valid2 = 1'b0; ready2 = 1'b0; data2 = 8'h00;
        rst1 = 1'b1; flush1 = 1'b0; valid1 = 1'b0; ready1 = 1'b0; data1 = 8'h00;
        #1;
        tick();
        tick();
        rst2 = 1'b0; rst1 = 1'b0;

        // ---------------- reset state ----------------
        chk2("rst2", 1'b0, 2'd0, 1'b1);
        chk1("rst1", 1'b0, 1'b0, 1'b1);
`ifdef DFF_PIPE_RESET_DATA_EN
        check("rst2.data", 32'(o_data2), 32'h0000_00A5);
        check("rst1.data", 32'(o_data1), 32'h0000_00A5);
`endif

        // ---------------- streaming, DEPTH=2 ----------------
        ready2 = 1'b1; valid2 = 1'b1; data2 = 8'h11;
        tick();
        chk2("str2.e1", 1'b0, 2'd1, 1'b1);
        data2 = 8'h22;
        tick();
        chk2("str2.e2", 1'b1, 2'd2, 1'b1);
        check("str2.e2.data", 32'(o_data2), 32'h11);
        data2 = 8'h33;
        tick();
        chk2("str2.e3", 1'b1, 2'd2, 1'b1);
        check("str2.e3.data", 32'(o_data2), 32'h22);
        valid2 = 1'b0;
        tick();
        chk2("str2.e4", 1'b1, 2'd1, 1'b1);
        check("str2.e4.data", 32'(o_data2), 32'h33);
        tick();
        chk2("str2.e5", 1'b0, 2'd0, 1'b1);

        // ---------------- backpressure, DEPTH=2 ----------------
        ready2 = 1'b0; valid2 = 1'b1; data2 = 8'hA1;
        tick();
        chk2("bp2.a1", 1'b0, 2'd1, 1'b1);
        data2 = 8'hA2;
        tick();
        chk2("bp2.a2", 1'b1, 2'd2, 1'b0);
        check("bp2.a2.data", 32'(o_data2), 32'hA1);
        data2 = 8'hA3;
        tick();
        chk2("bp2.hold", 1'b1, 2'd2, 1'b0);
        check("bp2.hold.data", 32'(o_data2), 32'hA1);
        ready2 = 1'b1;
        #1;
        check("bp2.full_ready", 32'(o_ready2), 32'h1);
        tick();
        chk2("bp2.o1", 1'b1, 2'd2, 1'b1);
        check("bp2.o1.data", 32'(o_data2), 32'hA2);
        valid2 = 1'b0;
        tick();
        chk2("bp2.o2", 1'b1, 2'd1, 1'b1);
        check("bp2.o2.data", 32'(o_data2), 32'hA3);
        tick();
        chk2("bp2.o3", 1'b0, 2'd0, 1'b1);
        tick();
        chk2("bp2.o4", 1'b0, 2'd0, 1'b1);

        // ---------------- bubble collapse ----------------
        ready2 = 1'b0; valid2 = 1'b1; data2 = 8'h55;
        tick();
        valid2 = 1'b0;
        chk2("bub.e1", 1'b0, 2'd1, 1'b1);
        tick();
        chk2("bub.e2", 1'b1, 2'd1, 1'b1);
        check("bub.e2.data", 32'(o_data2), 32'h55);

        // ---------------- flush on a full pipe ----------------
        valid2 = 1'b1; data2 = 8'h66;
        tick();
        chk2("fl.full", 1'b1, 2'd2, 1'b0);
        flush2 = 1'b1; data2 = 8'h77;
        #1;
        chk2("fl.cycle", 1'b1, 2'd2, 1'b0);
        tick();
        flush2 = 1'b0; valid2 = 1'b0;
        chk2("fl.after", 1'b0, 2'd0, 1'b1);
        ready2 = 1'b1;
        tick();
        chk2("fl.drain1", 1'b0, 2'd0, 1'b1);
        tick();
        chk2("fl.drain2", 1'b0, 2'd0, 1'b1);

        // Flush with an accepted input and a delivered output in the same cycle
        ready2 = 1'b0; valid2 = 1'b1; data2 = 8'h99;
        tick();
        valid2 = 1'b0;
        tick();
        chk2("fl2.pre", 1'b1, 2'd1, 1'b1);
        flush2 = 1'b1; valid2 = 1'b1; data2 = 8'h88; ready2 = 1'b1;
        tick();
        flush2 = 1'b0; valid2 = 1'b0;
        chk2("fl2.after", 1'b0, 2'd0, 1'b1);
        tick();
        chk2("fl2.drain1", 1'b0, 2'd0, 1'b1);
        tick();
        chk2("fl2.drain2", 1'b0, 2'd0, 1'b1);

        // ---------------- reset together with flush, mid-stream ----------------
        ready2 = 1'b0; valid2 = 1'b1; data2 = 8'hC1;
        tick();
        data2 = 8'hC2;
        tick();
        chk2("rf.full", 1'b1, 2'd2, 1'b0);
        rst2 = 1'b1; flush2 = 1'b1; data2 = 8'hC3;
        tick();
        rst2 = 1'b0; flush2 = 1'b0; valid2 = 1'b0;
        chk2("rf.after", 1'b0, 2'd0, 1'b1);
`ifdef DFF_PIPE_RESET_DATA_EN
        check("rf.data", 32'(o_data2), 32'h0000_00A5);
`endif
        ready2 = 1'b1;
        tick();
        chk2("rf.drain1", 1'b0, 2'd0, 1'b1);
        tick();
        chk2("rf.drain2", 1'b0, 2'd0, 1'b1);

        // ---------------- DEPTH=1 streaming ----------------
        ready1 = 1'b1; valid1 = 1'b1; data1 = 8'h11;
        tick();
        chk1("str1.e1", 1'b1, 1'b1, 1'b1);
        check("str1.e1.data", 32'(o_data1), 32'h11);
        data1 = 8'h22;
        tick();
        chk1("str1.e2", 1'b1, 1'b1, 1'b1);
        check("str1.e2.data", 32'(o_data1), 32'h22);
        data1 = 8'h33;
        tick();
        check("str1.e3.data", 32'(o_data1), 32'h33);
        valid1 = 1'b0;
        tick();
        chk1("str1.e4", 1'b0, 1'b0, 1'b1);

        // ---------------- DEPTH=1 backpressure ----------------
        ready1 = 1'b0; valid1 = 1'b1; data1 = 8'hA1;
        tick();
        chk1("bp1.a1", 1'b1, 1'b1, 1'b0);
        check("bp1.a1.data", 32'(o_data1), 32'hA1);
        data1 = 8'hA2;
        tick();
        chk1("bp1.hold", 1'b1, 1'b1, 1'b0);
        check("bp1.hold.data", 32'(o_data1), 32'hA1);
        ready1 = 1'b1;
        #1;
        check("bp1.full_ready", 32'(o_ready1), 32'h1);
        tick();
        chk1("bp1.o1", 1'b1, 1'b1, 1'b1);
        check("bp1.o1.data", 32'(o_data1), 32'hA2);
        valid1 = 1'b0;
        tick();
        chk1("bp1.o2", 1'b0, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
